// File: rtl/tdm_demux_14.sv
// Serial slot stream to four parallel channels. A hunt/locked FSM aligns on the
// frame marker and flywheels through up to NUM_MISS-1 consecutive missing markers.
module tdm_demux_14 #(
   parameter int WIDTH    = 8,
   parameter int NUM_MISS = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             fsync,
   output logic [WIDTH-1:0] ch0,
   output logic [WIDTH-1:0] ch1,
   output logic [WIDTH-1:0] ch2,
   output logic [WIDTH-1:0] ch3,
   output logic             frame_valid,
   output logic             locked,
   output logic             err_sync
);

   typedef enum logic {ST_HUNT = 1'b0, ST_LOCKED = 1'b1} state_t;

   state_t           r_state, w_state_next;
   logic [1:0]       r_cnt, w_cnt_next;
   logic [2:0]       r_miss, w_miss_next;
   logic [2:0]       w_miss_inc;
   logic             w_miss_drop;
   logic             w_load_sh0, w_load_sh1, w_load_sh2, w_frame, w_err;
   logic [WIDTH-1:0] r_sh0, r_sh1, r_sh2;
   logic [WIDTH-1:0] r_ch0, r_ch1, r_ch2, r_ch3;
   logic             r_frame_valid, r_err_sync;

   assign w_miss_inc  = r_miss + 3'd1;
   assign w_miss_drop = (w_miss_inc == 3'(NUM_MISS));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_HUNT;
         r_cnt   <= 2'd0;
         r_miss  <= 3'd0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_miss  <= w_miss_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_miss_next  = r_miss;
      if (din_valid) begin
         if (r_state == ST_HUNT) begin
            if (fsync) begin
               w_state_next = ST_LOCKED;
               w_cnt_next   = 2'd1;
               w_miss_next  = 3'd0;
            end
         end else if (r_cnt == 2'd0) begin
            if (fsync) begin
               w_cnt_next  = 2'd1;
               w_miss_next = 3'd0;
            end else if (w_miss_drop) begin
               w_state_next = ST_HUNT;
               w_cnt_next   = 2'd0;
               w_miss_next  = 3'd0;
            end else begin
               w_cnt_next  = 2'd1;
               w_miss_next = w_miss_inc;
            end
         end else if (fsync) begin
            // Early marker realigns to slot 0; miss count is deliberately kept
            w_cnt_next = 2'd1;
         end else begin
            w_cnt_next = r_cnt + 2'd1;
         end
      end
   end

   always_comb begin
      w_load_sh0 = 1'b0;
      w_load_sh1 = 1'b0;
      w_load_sh2 = 1'b0;
      w_frame    = 1'b0;
      w_err      = 1'b0;
      if (din_valid) begin
         if (r_state == ST_HUNT) begin
            w_load_sh0 = fsync;
         end else if (r_cnt == 2'd0) begin
            w_err      = !fsync;
            w_load_sh0 = fsync || !w_miss_drop;
         end else if (fsync) begin
            w_err      = 1'b1;
            w_load_sh0 = 1'b1;
         end else begin
            w_load_sh1 = (r_cnt == 2'd1);
            w_load_sh2 = (r_cnt == 2'd2);
            w_frame    = (r_cnt == 2'd3);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh0         <= '0;
         r_sh1         <= '0;
         r_sh2         <= '0;
         r_ch0         <= '0;
         r_ch1         <= '0;
         r_ch2         <= '0;
         r_ch3         <= '0;
         r_frame_valid <= 1'b0;
         r_err_sync    <= 1'b0;
      end else begin
         if (w_load_sh0) r_sh0 <= din;
         if (w_load_sh1) r_sh1 <= din;
         if (w_load_sh2) r_sh2 <= din;
         if (w_frame) begin
            r_ch0 <= r_sh0;
            r_ch1 <= r_sh1;
            r_ch2 <= r_sh2;
            r_ch3 <= din;
         end
         r_frame_valid <= w_frame;
         r_err_sync    <= w_err;
      end
   end

   assign ch0         = r_ch0;
   assign ch1         = r_ch1;
   assign ch2         = r_ch2;
   assign ch3         = r_ch3;
   assign frame_valid = r_frame_valid;
   assign err_sync    = r_err_sync;
   assign locked      = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_tdm_demux_14.sv
// Table-driven bench for tdm_demux_14: per-beat flag checks plus a frame scoreboard.
module tb_tdm_demux_14;

   logic       clk;
   logic       rst_n;
   logic [7:0] din;
   logic       din_valid;
   logic       fsync;
   logic [7:0] ch0, ch1, ch2, ch3;
   logic       frame_valid, locked, err_sync;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        v;
      logic        fs;
      logic [7:0]  d;
      logic        e_err;
      logic        e_lock;
      logic        e_fv;
      logic [31:0] e_ch;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] exp_q[$];

   tdm_demux_14 #(.WIDTH(8), .NUM_MISS(2)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .fsync(fsync),
      .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
      .frame_valid(frame_valid), .locked(locked), .err_sync(err_sync)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic vec_t mk(input logic v, input logic fs, input logic [7:0] d,
                               input logic err, input logic lk, input logic fv,
                               input logic [31:0] ch);
      vec_t t;
      t.v = v; t.fs = fs; t.d = d; t.e_err = err; t.e_lock = lk; t.e_fv = fv; t.e_ch = ch;
      return t;
   endfunction

   task automatic apply(input vec_t t);
      @(negedge clk);
      din_valid = t.v;
      fsync     = t.fs;
      din       = t.d;
      @(posedge clk);
      #1;
      $display("txn v=%0b fs=%0b din=%h -> err=%0b locked=%0b fv=%0b ch=%h%h%h%h",
               t.v, t.fs, t.d, err_sync, locked, frame_valid, ch0, ch1, ch2, ch3);
      chk("err_sync", 32'(err_sync), 32'(t.e_err));
      chk("locked", 32'(locked), 32'(t.e_lock));
      chk("frame_valid", 32'(frame_valid), 32'(t.e_fv));
      if (t.e_fv) exp_q.push_back(t.e_ch);
   endtask

   // Scoreboard: every frame_valid pulse must match the oldest expected frame
   always @(negedge clk) begin
      if (rst_n && frame_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_frame", {ch0, ch1, ch2, ch3}, 32'hxxxx_xxxx);
         end else begin
            chk("frame_ch", {ch0, ch1, ch2, ch3}, exp_q.pop_front());
         end
      end
   end

   // Frame with the given four bytes; slot 0 carries fsync=fs0 and err=err0
   task automatic add_frame(input logic fs0, input logic err0, input logic [31:0] f);
      vecs.push_back(mk(1, fs0, f[31:24], err0, 1, 0, 0));
      vecs.push_back(mk(1, 0, f[23:16], 0, 1, 0, 0));
      vecs.push_back(mk(1, 0, f[15:8], 0, 1, 0, 0));
      vecs.push_back(mk(1, 0, f[7:0], 0, 1, 1, f));
   endtask

   initial begin
      logic [31:0] gap;
      rst_n = 1'b0; din = '0; din_valid = 1'b0; fsync = 1'b0;
      #12;
      chk("rst_ch", {ch0, ch1, ch2, ch3}, 32'h0);
      chk("rst_flags", {29'd0, frame_valid, locked, err_sync}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Hunt: beats without fsync and idle fsync are ignored
      vecs.push_back(mk(1, 0, 8'h55, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 8'h66, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 8'h77, 0, 0, 0, 0));
      add_frame(1, 0, 32'hA1B2C3D4);
      // Gapped frame, idle cycles carry fsync=1 which must be ignored
      gap = 32'h10203040;
      for (int i = 0; i < 4; i++) begin
         vecs.push_back(mk(1, (i == 0), gap[31-8*i -: 8], 0, 1, (i == 3), gap));
         for (int j = 0; j < 3; j++) vecs.push_back(mk(0, 1, 8'hFF, 0, 1, 0, 0));
      end
      // Flywheel one miss, then second consecutive miss drops lock
      add_frame(0, 1, 32'h11223344);
      vecs.push_back(mk(1, 0, 8'h99, 1, 0, 0, 0));
      vecs.push_back(mk(1, 0, 8'h98, 0, 0, 0, 0));
      // Early marker
      vecs.push_back(mk(1, 1, 8'h01, 0, 1, 0, 0));
      vecs.push_back(mk(1, 0, 8'h02, 0, 1, 0, 0));
      vecs.push_back(mk(1, 1, 8'h05, 1, 1, 0, 0));
      vecs.push_back(mk(1, 0, 8'h06, 0, 1, 0, 0));
      vecs.push_back(mk(1, 0, 8'h07, 0, 1, 0, 0));
      vecs.push_back(mk(1, 0, 8'h08, 0, 1, 1, 32'h05060708));
      // Marker recovery resets the miss count
      add_frame(0, 1, 32'hE1E2E3E4);
      add_frame(1, 0, 32'hF1F2F3F4);
      add_frame(0, 1, 32'hC1C2C3C4);
      vecs.push_back(mk(1, 0, 8'h9A, 1, 0, 0, 0));

      foreach (vecs[k]) apply(vecs[k]);
      @(negedge clk);
      chk("ch_hold_after_drop", {ch0, ch1, ch2, ch3}, 32'hC1C2C3C4);

      // Asynchronous reset mid-frame
      apply(mk(1, 1, 8'h5A, 0, 1, 0, 0));
      apply(mk(1, 0, 8'h5B, 0, 1, 0, 0));
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_ch", {ch0, ch1, ch2, ch3}, 32'h0);
      chk("async_rst_locked", 32'(locked), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      apply(mk(1, 0, 8'h5C, 0, 0, 0, 0));
      apply(mk(1, 0, 8'h5D, 0, 0, 0, 0));
      vecs.delete();
      add_frame(1, 0, 32'h31323334);
      add_frame(1, 0, 32'h41424344);
      foreach (vecs[k]) apply(vecs[k]);
      apply(mk(0, 0, 8'h00, 0, 1, 0, 0));

      @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
